// File: rtl/game_session_mux_pkg.sv
// Shared types and constants for the multi-lane game session controller.
package game_pkg;

    localparam int unsigned COLOR_W = 12;
    localparam int unsigned H_W     = 11;

    typedef enum logic [2:0] {
        S_IDLE,
        S_REGEN,
        S_RUN,
        S_PAUSE,
        S_WIN,
        S_LOSE
    } state_e;

    localparam int unsigned BANNER_IDLE  = 0;
    localparam int unsigned BANNER_PAUSE = 1;
    localparam int unsigned BANNER_WIN   = 2;
    localparam int unsigned BANNER_LOSE  = 3;

    localparam logic [1:0] LED_OFF  = 2'b00;
    localparam logic [1:0] LED_PLAY = 2'b01;
    localparam logic [1:0] LED_WON  = 2'b10;
    localparam logic [1:0] LED_LOST = 2'b11;

    // Index width that stays legal for a single lane.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/game_session_mux_if.sv
// Pixel-coordinate to lane-index bus between the mux and its lane decoder.
interface game_session_mux_if #(
    parameter int unsigned N_GAMES = 2
);
    localparam int unsigned IDX_W = game_pkg::idx_width(N_GAMES);

    logic [game_pkg::H_W-1:0] h_coord;
    logic [IDX_W-1:0]         lane_idx;

    modport master (output h_coord, input lane_idx);
    modport slave  (input h_coord, output lane_idx);
endinterface

// File: rtl/game_session_mux_lane_select.sv
// Maps a horizontal coordinate to its side-by-side lane using constant thresholds.
module lane_select
    import game_pkg::*;
#(
    parameter int unsigned N_GAMES      = 2,
    parameter int unsigned SCREEN_WIDTH = 800
) (
    game_session_mux_if.slave sel
);

    localparam int unsigned IDX_W  = idx_width(N_GAMES);
    localparam int unsigned LANE_W = SCREEN_WIDTH / N_GAMES;

    logic [IDX_W-1:0] idx_c;

    // Last threshold passed wins; anything past the screen lands on the final lane.
    always_comb begin
        idx_c = '0;
        for (int unsigned k = 1; k < N_GAMES; k++) begin
            if (sel.h_coord >= H_W'(k * LANE_W)) idx_c = IDX_W'(k);
        end
    end

    assign sel.lane_idx = idx_c;

endmodule

// File: rtl/game_session_mux.sv
// Session FSM for N side-by-side game lanes plus the registered pixel mux.
module game_session_mux
    import game_pkg::*;
#(
    parameter int unsigned N_GAMES      = 2,
    parameter int unsigned SCREEN_WIDTH = 800,
    parameter int unsigned RATING_WIDTH = 8,
    parameter int unsigned NUM_IMAGES   = 4
) (
    input  logic                          clk,
    input  logic                          arst_n,
    input  logic                          i_btn_start,
    input  logic                          i_btn_pause,
    input  logic [N_GAMES-1:0]            i_game_en,
    input  logic [N_GAMES-1:0]            i_win,
    input  logic [N_GAMES-1:0]            i_lose,
    input  logic [N_GAMES-1:0]            i_ready,
    input  logic [COLOR_W*N_GAMES-1:0]    i_game_rgb,
    input  logic [COLOR_W-1:0]            i_banner_rgb,
    input  logic [H_W-1:0]                i_h_coord,
    input  logic                          i_disp_enbl,
    output logic [COLOR_W-1:0]            o_rgb,
    output logic [N_GAMES-1:0]            o_pause,
    output logic [N_GAMES-1:0]            o_regen,
    output logic [RATING_WIDTH-1:0]       o_rating,
    output logic [$clog2(NUM_IMAGES)-1:0] o_banner_num,
    output logic [2*N_GAMES-1:0]          o_game_state
);

    localparam int unsigned IDX_W    = idx_width(N_GAMES);
    localparam int unsigned BANNER_W = $clog2(NUM_IMAGES);

    state_e                  state_q, state_d;
    logic [N_GAMES-1:0]      mask_q, mask_d, flags_q, flags_d, lost_q, lost_d;
    logic [N_GAMES-1:0]      regen_q, regen_d, pause_q, pause_d;
    logic [RATING_WIDTH-1:0] rating_q, rating_d;
    logic [BANNER_W-1:0]     banner_q, banner_d;
    logic [2*N_GAMES-1:0]    led_q, led_d;
    logic [COLOR_W-1:0]      rgb_q, rgb_d, lane_rgb_c;
    logic                    start_prev_q, pause_prev_q, armed_q;
    logic                    start_edge_c, pause_edge_c, mask_sel_c;
    logic [N_GAMES-1:0]      won_c, lose_c;
    logic [IDX_W-1:0]        lane_idx;

    game_session_mux_if #(.N_GAMES(N_GAMES)) sel_if ();

    assign sel_if.h_coord = i_h_coord;
    assign lane_idx       = sel_if.lane_idx;

    lane_select #(
        .N_GAMES      (N_GAMES),
        .SCREEN_WIDTH (SCREEN_WIDTH)
    ) u_lane_select (
        .sel (sel_if.slave)
    );

    // armed_q masks the first cycle after reset so a held button cannot fake an edge.
    assign start_edge_c = armed_q & i_btn_start & ~start_prev_q;
    assign pause_edge_c = armed_q & i_btn_pause & ~pause_prev_q;
    assign won_c        = flags_q | (i_win & mask_q);
    assign lose_c       = i_lose & mask_q;

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state_q      <= S_IDLE;
            mask_q       <= '0;
            flags_q      <= '0;
            lost_q       <= '0;
            rating_q     <= '0;
            regen_q      <= '0;
            pause_q      <= '1;
            banner_q     <= '0;
            led_q        <= '0;
            rgb_q        <= '0;
            start_prev_q <= 1'b0;
            pause_prev_q <= 1'b0;
            armed_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            mask_q       <= mask_d;
            flags_q      <= flags_d;
            lost_q       <= lost_d;
            rating_q     <= rating_d;
            regen_q      <= regen_d;
            pause_q      <= pause_d;
            banner_q     <= banner_d;
            led_q        <= led_d;
            rgb_q        <= rgb_d;
            start_prev_q <= i_btn_start;
            pause_prev_q <= i_btn_pause;
            armed_q      <= 1'b1;
        end
    end

    // Next state plus outputs decoded from the next state so they align with state_q.
    always_comb begin
        state_d  = state_q;
        mask_d   = mask_q;
        flags_d  = flags_q;
        lost_d   = lost_q;
        rating_d = rating_q;
        regen_d  = '0;
        pause_d  = '1;
        banner_d = '0;
        led_d    = '0;

        case (state_q)
            S_IDLE: begin
                if (start_edge_c && (|i_game_en)) begin
                    state_d = S_REGEN;
                    mask_d  = i_game_en;
                end
            end
            S_REGEN: begin
                // regen_q is non-zero only during the pulse cycle, so ready is sampled after it.
                if ((regen_q == '0) && (&(i_ready | ~mask_q))) state_d = S_RUN;
            end
            S_RUN: begin
                if (|lose_c) begin
                    state_d = S_LOSE;
                    lost_d  = lose_c;
                end else begin
                    flags_d = won_c;
                    if (&(won_c | ~mask_q)) state_d = S_WIN;
                    else if (pause_edge_c)  state_d = S_PAUSE;
                end
            end
            S_PAUSE: if (start_edge_c) state_d = S_RUN;
            S_WIN: begin
                if (start_edge_c) begin
                    state_d  = S_REGEN;
                    rating_d = (&rating_q) ? rating_q : rating_q + RATING_WIDTH'(1);
                end
            end
            S_LOSE: begin
                if (start_edge_c) begin
                    state_d  = S_REGEN;
                    rating_d = '0;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if ((state_d == S_REGEN) && (state_q != S_REGEN)) begin
            flags_d = '0;
            lost_d  = '0;
            regen_d = mask_d;
        end

        if (state_d == S_RUN) pause_d = ~mask_d;

        case (state_d)
            S_PAUSE: banner_d = BANNER_W'(BANNER_PAUSE);
            S_WIN:   banner_d = BANNER_W'(BANNER_WIN);
            S_LOSE:  banner_d = BANNER_W'(BANNER_LOSE);
            default: banner_d = BANNER_W'(BANNER_IDLE);
        endcase

        for (int unsigned k = 0; k < N_GAMES; k++) begin
            if (state_d == S_LOSE)
                led_d[2*k +: 2] = lost_d[k] ? LED_LOST : LED_OFF;
            else if ((state_d != S_IDLE) && mask_d[k])
                led_d[2*k +: 2] = flags_d[k] ? LED_WON : LED_PLAY;
        end
    end

    // Pixel path: one register stage after the coordinate and colour inputs.
    always_comb begin
        lane_rgb_c = '0;
        mask_sel_c = 1'b0;
        rgb_d      = '0;
        for (int unsigned k = 0; k < N_GAMES; k++) begin
            if (lane_idx == IDX_W'(k)) begin
                lane_rgb_c = i_game_rgb[COLOR_W*k +: COLOR_W];
                mask_sel_c = mask_q[k];
            end
        end
        if (i_disp_enbl) begin
            if (state_q != S_RUN) rgb_d = i_banner_rgb;
            else if (mask_sel_c)  rgb_d = lane_rgb_c;
        end
    end

    assign o_rgb        = rgb_q;
    assign o_pause      = pause_q;
    assign o_regen      = regen_q;
    assign o_rating     = rating_q;
    assign o_banner_num = banner_q;
    assign o_game_state = led_q;

endmodule
